// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
//   Wishbone-classic arbiter that lets two masters share one single-port memory.
//   The masters are the control unit's instruction-fetch port and its data port.
//   Once a master holds the grant, transfers pass through with no added wait
//   states. A bus-timeout watchdog returns err if the memory never acks, so the
//   CPU cannot hang on a missing ack.
//
//   Parameters
//     AW       address width
//     DW       data width
//     RR       0: fixed priority (data wins); 1: round-robin on simultaneous request
//     TIMEOUT  strobe-without-ack cycles before err is returned; 0 disables
//
//   Ports
//     clk, rst                      clock (rising edge), async reset (active-low)
//     inst_cyc_i/stb_i/adr_i        fetch master request
//     inst_ack_o/err_o/dat_o        fetch master response
//     data_cyc_i/stb_i/we_i/adr_i   data master request
//     data_dat_i                    data master write data
//     data_ack_o/err_o/dat_o        data master response
//     mem_cyc_o/stb_o/we_o          memory port control
//     mem_adr_o/dat_o               memory port address / write data
//     mem_dat_i, mem_ack_i          memory port read data / ack
//     grant_o                       01 inst owns bus, 10 data owns bus, 00 idle
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no owner; memory port quiet; arbitrate every cycle
//   GNT_I | fetch master owns the memory port until its cyc drops
//   GNT_D | data master owns the memory port until its cyc drops
// -----------------------------------------------------------------------------
module wb_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR      = 0,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          inst_cyc_i,
    input  logic          inst_stb_i,
    input  logic [AW-1:0] inst_adr_i,
    output logic          inst_ack_o,
    output logic          inst_err_o,
    output logic [DW-1:0] inst_dat_o,

    input  logic          data_cyc_i,
    input  logic          data_stb_i,
    input  logic          data_we_i,
    input  logic [AW-1:0] data_adr_i,
    input  logic [DW-1:0] data_dat_i,
    output logic          data_ack_o,
    output logic          data_err_o,
    output logic [DW-1:0] data_dat_o,

    output logic          mem_cyc_o,
    output logic          mem_stb_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [DW-1:0] mem_dat_o,
    input  logic [DW-1:0] mem_dat_i,
    input  logic          mem_ack_i,

    output logic [1:0]    grant_o
);

    // Encodings double as the grant_o value.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t pick;
    logic   last_gnt_data;   // 0: fetch master was granted last, 1: data master
    logic   xfer_ack;
    logic   timeout_hit;

    // Winner if the bus were free this cycle.
    always_comb begin
        pick = IDLE;
        if (inst_cyc_i && data_cyc_i) begin
            if (RR != 0)
                pick = last_gnt_data ? GNT_I : GNT_D;
            else
                pick = GNT_D;
        end else if (data_cyc_i) begin
            pick = GNT_D;
        end else if (inst_cyc_i) begin
            pick = GNT_I;
        end
    end

    // The owner keeps the bus while its cyc stays high. Handover to the next
    // master happens in the same cycle the owner lets go, so there is no dead cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pick;
            GNT_I:   if (!inst_cyc_i) state_nxt = pick;
            GNT_D:   if (!data_cyc_i) state_nxt = pick;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_gnt_data <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == GNT_I)
                last_gnt_data <= 1'b0;
            else if (state_nxt == GNT_D)
                last_gnt_data <= 1'b1;
        end
    end

    // The memory-port mux is decoded from the registered state. An async reset
    // therefore drops the bus at once, without waiting for a clock edge.
    // The strobe is qualified with cyc. Once the owner has let go, a late
    // mem_ack_i matches no strobe and is discarded.
    always_comb begin
        mem_cyc_o = 1'b0;
        mem_stb_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_adr_o = '0;
        mem_dat_o = '0;
        case (state)
            GNT_I: begin
                mem_cyc_o = inst_cyc_i;
                mem_stb_o = inst_cyc_i & inst_stb_i;
                mem_adr_o = inst_adr_i;
            end
            GNT_D: begin
                mem_cyc_o = data_cyc_i;
                mem_stb_o = data_cyc_i & data_stb_i;
                mem_we_o  = data_cyc_i & data_we_i;
                mem_adr_o = data_adr_i;
                mem_dat_o = data_dat_i;
            end
            default: ;
        endcase
    end

    assign xfer_ack = mem_stb_o & mem_ack_i;

    // The watchdog counts strobe cycles that get no ack. err is raised during
    // the TIMEOUT-th such cycle. An ack in that same cycle wins over err.
    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] wd_cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    wd_cnt <= '0;
                else if ((state_nxt != state) || !mem_stb_o || mem_ack_i || timeout_hit)
                    wd_cnt <= '0;
                else
                    wd_cnt <= wd_cnt + 1'b1;
            end

            assign timeout_hit = mem_stb_o & ~mem_ack_i & (wd_cnt == WD_LAST);
        end else begin : g_no_wd
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign inst_ack_o = (state == GNT_I) & xfer_ack;
    assign inst_err_o = (state == GNT_I) & timeout_hit;
    assign data_ack_o = (state == GNT_D) & xfer_ack;
    assign data_err_o = (state == GNT_D) & timeout_hit;

    assign inst_dat_o = mem_dat_i;
    assign data_dat_o = mem_dat_i;

    assign grant_o = state;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        inst_cyc = 1'b0, inst_stb = 1'b0;
    logic [31:0] inst_adr = '0;
    logic        data_cyc = 1'b0, data_stb = 1'b0, data_we = 1'b0;
    logic [31:0] data_adr = '0, data_wdat = '0;
    logic        ack_en = 1'b0;

    // Fixed-priority instance (RR=0).
    logic        i_ack0, i_err0, d_ack0, d_err0, m_cyc0, m_stb0, m_we0, mem_ack0;
    logic [31:0] i_dat0, d_dat0, m_adr0, m_dat0, mem_rd0;
    logic [1:0]  grant0;
    // Round-robin instance (RR=1).
    logic        i_ack1, i_err1, d_ack1, d_err1, m_cyc1, m_stb1, m_we1, mem_ack1;
    logic [31:0] i_dat1, d_dat1, m_adr1, m_dat1, mem_rd1;
    logic [1:0]  grant1;

    // Memory model: zero-wait ack while ack_en is set; read data is derived from address.
    assign mem_ack0 = ack_en & m_stb0;
    assign mem_ack1 = ack_en & m_stb1;
    assign mem_rd0  = m_adr0 ^ 32'h5A5A_0000;
    assign mem_rd1  = m_adr1 ^ 32'h5A5A_0000;

    wb_mem_arbiter #(.AW(32), .DW(32), .RR(0), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst(rst),
        .inst_cyc_i(inst_cyc), .inst_stb_i(inst_stb), .inst_adr_i(inst_adr),
        .inst_ack_o(i_ack0), .inst_err_o(i_err0), .inst_dat_o(i_dat0),
        .data_cyc_i(data_cyc), .data_stb_i(data_stb), .data_we_i(data_we),
        .data_adr_i(data_adr), .data_dat_i(data_wdat),
        .data_ack_o(d_ack0), .data_err_o(d_err0), .data_dat_o(d_dat0),
        .mem_cyc_o(m_cyc0), .mem_stb_o(m_stb0), .mem_we_o(m_we0),
        .mem_adr_o(m_adr0), .mem_dat_o(m_dat0), .mem_dat_i(mem_rd0),
        .mem_ack_i(mem_ack0), .grant_o(grant0));

    wb_mem_arbiter #(.AW(32), .DW(32), .RR(1), .TIMEOUT(16)) dut1 (
        .clk(clk), .rst(rst),
        .inst_cyc_i(inst_cyc), .inst_stb_i(inst_stb), .inst_adr_i(inst_adr),
        .inst_ack_o(i_ack1), .inst_err_o(i_err1), .inst_dat_o(i_dat1),
        .data_cyc_i(data_cyc), .data_stb_i(data_stb), .data_we_i(data_we),
        .data_adr_i(data_adr), .data_dat_i(data_wdat),
        .data_ack_o(d_ack1), .data_err_o(d_err1), .data_dat_o(d_dat1),
        .mem_cyc_o(m_cyc1), .mem_stb_o(m_stb1), .mem_we_o(m_we1),
        .mem_adr_o(m_adr1), .mem_dat_o(m_dat1), .mem_dat_i(mem_rd1),
        .mem_ack_i(mem_ack1), .grant_o(grant1));

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_data;
        bit          is_err;
        logic [31:0] dat;
    } resp_t;
    resp_t sb_q[$];

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic expect_resp(input bit is_data, input bit is_err, input logic [31:0] a);
        resp_t r;
        r.is_data = is_data;
        r.is_err  = is_err;
        r.dat     = rd_of(a);
        sb_q.push_back(r);
    endtask

    task automatic sb_pop(input bit is_data, input bit is_err, input logic [31:0] dat);
        resp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got data=%0d err=%0d dat=%h, required no response", is_data, is_err, dat);
        end else begin
            e = sb_q.pop_front();
            if (e.is_data != is_data || e.is_err != is_err || (!is_err && e.dat !== dat)) begin
                errors++;
                $display("FAIL sb_resp: got data=%0d err=%0d dat=%h, required data=%0d err=%0d dat=%h",
                         is_data, is_err, dat, e.is_data, e.is_err, e.dat);
            end
        end
    endtask

    // Monitor on dut0: every response the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (i_ack0) sb_pop(1'b0, 1'b0, i_dat0);
        if (i_err0) sb_pop(1'b0, 1'b1, i_dat0);
        if (d_ack0) sb_pop(1'b1, 1'b0, d_dat0);
        if (d_err0) sb_pop(1'b1, 1'b1, d_dat0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_exp [4];

    initial begin
        rr_exp[0] = 2'b10; rr_exp[1] = 2'b01; rr_exp[2] = 2'b10; rr_exp[3] = 2'b01;

        // 1: reset held while both masters request
        inst_cyc = 1'b1; inst_stb = 1'b1; data_cyc = 1'b1; data_stb = 1'b1;
        tick(); tick();
        chk("rst_grant", 32'(grant0), 32'h0);
        chk("rst_mem_cyc", 32'(m_cyc0), 32'h0);
        chk("rst_acks", {30'h0, i_ack0, d_ack0}, 32'h0);
        inst_cyc = 1'b0; inst_stb = 1'b0; data_cyc = 1'b0; data_stb = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // 2: simultaneous request, fixed priority -> data 4-beat read, then inst
        ack_en = 1'b1;
        inst_cyc = 1'b1; inst_stb = 1'b1; inst_adr = 32'h40;
        data_cyc = 1'b1; data_stb = 1'b1; data_adr = 32'h200;
        tick();
        chk("sim_grant_data", 32'(grant0), 32'h2);
        for (int i = 0; i < 4; i++) begin
            data_adr = 32'h200 + 32'(4 * i);
            expect_resp(1'b1, 1'b0, data_adr);
            tick();
        end
        data_cyc = 1'b0; data_stb = 1'b0;
        expect_resp(1'b0, 1'b0, 32'h40);
        tick();
        chk("sim_grant_inst", 32'(grant0), 32'h1);
        tick();
        inst_cyc = 1'b0; inst_stb = 1'b0;
        tick();

        // 4: data write passes through; inst grant forces we low
        data_cyc = 1'b1; data_stb = 1'b1; data_we = 1'b1;
        data_adr = 32'h100; data_wdat = 32'hDEAD_BEEF;
        expect_resp(1'b1, 1'b0, 32'h100);
        tick();
        chk("wr_grant", 32'(grant0), 32'h2);
        chk("wr_mem_we", 32'(m_we0), 32'h1);
        chk("wr_mem_adr", m_adr0, 32'h100);
        chk("wr_mem_dat", m_dat0, 32'hDEAD_BEEF);
        tick();
        data_cyc = 1'b0; data_stb = 1'b0;
        inst_cyc = 1'b1; inst_stb = 1'b1; inst_adr = 32'h80;
        expect_resp(1'b0, 1'b0, 32'h80);
        tick();
        chk("gnti_grant", 32'(grant0), 32'h1);
        chk("gnti_mem_we", 32'(m_we0), 32'h0);
        chk("gnti_mem_adr", m_adr0, 32'h80);
        tick();
        inst_cyc = 1'b0; inst_stb = 1'b0; data_we = 1'b0;
        tick();

        // 3: repeated simultaneous requests from IDLE (cyc only, no strobe)
        for (int r = 0; r < 4; r++) begin
            inst_cyc = 1'b1; data_cyc = 1'b1;
            tick();
            chk("rr_grant", 32'(grant1), 32'(rr_exp[r]));
            chk("fixed_grant", 32'(grant0), 32'h2);
            inst_cyc = 1'b0; data_cyc = 1'b0;
            tick();
        end

        // 5a: no ack -> err during the 16th strobe cycle
        ack_en = 1'b0;
        data_cyc = 1'b1; data_stb = 1'b1; data_adr = 32'h300;
        tick();
        for (int n = 1; n <= 16; n++) begin
            if (n == 16) expect_resp(1'b1, 1'b1, 32'h300);
            chk("to_err_timing", 32'(d_err0), (n == 16) ? 32'h1 : 32'h0);
            tick();
        end
        data_cyc = 1'b0; data_stb = 1'b0;
        tick();
        tick();

        // 5b: ack arrives on the timeout cycle -> ack wins
        data_cyc = 1'b1; data_stb = 1'b1; data_adr = 32'h304;
        tick();
        for (int n = 1; n < 16; n++) tick();
        ack_en = 1'b1;
        expect_resp(1'b1, 1'b0, 32'h304);
        #1;
        chk("to_ack_wins_ack", 32'(d_ack0), 32'h1);
        chk("to_ack_wins_err", 32'(d_err0), 32'h0);
        tick();
        ack_en = 1'b0; data_cyc = 1'b0; data_stb = 1'b0;
        tick();

        // 6: async reset mid-burst, then fresh arbitration
        ack_en = 1'b1;
        data_cyc = 1'b1; data_stb = 1'b1; data_adr = 32'h400;
        tick();
        chk("burst_grant", 32'(grant0), 32'h2);
        expect_resp(1'b1, 1'b0, 32'h400);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("async_rst_mem_cyc", 32'(m_cyc0), 32'h0);
        chk("async_rst_grant", 32'(grant0), 32'h0);
        data_cyc = 1'b0; data_stb = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        inst_cyc = 1'b1; inst_stb = 1'b1; inst_adr = 32'h500;
        tick();
        chk("post_rst_grant", 32'(grant0), 32'h1);
        expect_resp(1'b0, 1'b0, 32'h500);
        tick();
        inst_cyc = 1'b0; inst_stb = 1'b0; ack_en = 1'b0;
        tick();
        tick();

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
